// File: rtl/ltl_automata_pkg.sv
// ltl_automata_pkg
// Shared definitions for the programmable automaton:
//   - state_t        : stream-control FSM states
//   - CFG_SEL_*      : configuration table selectors for cfg_sel
//   - max_int        : helper used to size the configuration address port
package ltl_automata_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] CFG_SEL_CLASS  = 3'd0;  // class row for one symbol
  localparam logic [2:0] CFG_SEL_PRED   = 3'd1;  // predecessor mask of one STE
  localparam logic [2:0] CFG_SEL_SOD    = 3'd2;  // start-of-data mask
  localparam logic [2:0] CFG_SEL_ALLIN  = 3'd3;  // all-input mask
  localparam logic [2:0] CFG_SEL_REPORT = 3'd4;  // report mask

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ltl_ste_vec.sv
// ltl_ste_vec
// Combinational next-active computation for a vector of STEs.
// An STE becomes active when the current symbol is in its class and it is
// enabled by an active predecessor, by start-of-data on the first symbol,
// or unconditionally by its all-input bit.
// Ports:
//   active      in  NUM_STE            current active vector
//   class_row   in  NUM_STE            class row selected by the current symbol
//   pred        in  NUM_STE*NUM_STE    predecessor masks, STE i at [i*NUM_STE +: NUM_STE]
//   sod         in  NUM_STE            start-of-data mask
//   allin       in  NUM_STE            all-input mask
//   first       in  1                  current symbol is the first of the stream
//   next_active out NUM_STE            active vector after this symbol
module ltl_ste_vec #(
  parameter int NUM_STE = 16
) (
  input  logic [NUM_STE-1:0]         active,
  input  logic [NUM_STE-1:0]         class_row,
  input  logic [NUM_STE*NUM_STE-1:0] pred,
  input  logic [NUM_STE-1:0]         sod,
  input  logic [NUM_STE-1:0]         allin,
  input  logic                       first,
  output logic [NUM_STE-1:0]         next_active
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STE; gi++) begin : g_ste
      assign next_active[gi] = class_row[gi] &
                               ((|(active & pred[gi*NUM_STE +: NUM_STE])) |
                                (first & sod[gi]) |
                                allin[gi]);
    end
  endgenerate

endmodule

// File: rtl/ltl_prog_automaton.sv
// ltl_prog_automaton
// Programmable homogeneous automaton: a vector of STEs driven by a symbol
// stream, with runtime-writable class, predecessor, start-of-data,
// all-input and report tables.
// Optional feature macro: LTL_PROG_AUTOMATON_REPORT_CNT_EN adds the
// report_cnt port and its saturating counter.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cfg_we/cfg_sel/cfg_addr/cfg_wdata configuration write (idle only)
//   cfg_err                          pulse the cycle after a rejected write
//   start                            begins a stream (idle only)
//   sym_valid/sym_ready/sym_data/sym_last  symbol stream handshake
//   report/report_valid              masked active vector, one cycle after accept
//   report_any                       sticky "some report seen" for this stream
//   done                             single-cycle end-of-stream pulse
//   busy                             high whenever not idle
//   report_cnt                       (macro only) count of non-zero report cycles
module ltl_prog_automaton
  import ltl_automata_pkg::*;
#(
  parameter int NUM_STE = 16,
  parameter int SYM_W   = 8,
  parameter int CNT_W   = 16,
  localparam int ADDR_W = max_int(SYM_W, $clog2(NUM_STE))
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_sel,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [NUM_STE-1:0] cfg_wdata,
  output logic               cfg_err,
  input  logic               start,
  input  logic               sym_valid,
  output logic               sym_ready,
  input  logic [SYM_W-1:0]   sym_data,
  input  logic               sym_last,
  output logic [NUM_STE-1:0] report,
  output logic               report_valid,
  output logic               report_any,
  output logic               done,
  output logic               busy
`ifdef LTL_PROG_AUTOMATON_REPORT_CNT_EN
  ,
  output logic [CNT_W-1:0]   report_cnt
`endif
);

  localparam int NUM_SYM = 2 ** SYM_W;

  state_t state_reg, state_next;

  logic [NUM_STE-1:0] class_mem [NUM_SYM];
  logic [NUM_STE-1:0] pred_mem  [NUM_STE];
  logic [NUM_STE-1:0] sod_reg, allin_reg, rep_mask_reg;
  logic [NUM_STE-1:0] active_reg, report_reg;
  logic               report_valid_reg, report_any_reg, cfg_err_reg;

  logic [NUM_STE*NUM_STE-1:0] pred_flat;
  logic [NUM_STE-1:0]         class_row, next_active, next_report;
  logic                       first, accept, stream_begin;
  logic                       addr_ok, cfg_ok;

  // Configuration write qualification: tables are frozen while busy, and
  // addresses outside the table being written are rejected.
  always_comb begin
    addr_ok = 1'b0;
    case (cfg_sel)
      CFG_SEL_CLASS:  addr_ok = (int'(cfg_addr) < NUM_SYM);
      CFG_SEL_PRED,
      CFG_SEL_SOD,
      CFG_SEL_ALLIN,
      CFG_SEL_REPORT: addr_ok = (int'(cfg_addr) < NUM_STE);
      default:        addr_ok = 1'b0;
    endcase
  end

  assign cfg_ok = cfg_we & ~busy & addr_ok;

  always_ff @(posedge clk) begin
    if (reset) cfg_err_reg <= 1'b0;
    else       cfg_err_reg <= cfg_we & ~cfg_ok;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SYM; gi++) begin : g_class
      always_ff @(posedge clk) begin
        if (reset)
          class_mem[gi] <= '0;
        else if (cfg_ok && cfg_sel == CFG_SEL_CLASS && int'(cfg_addr) == gi)
          class_mem[gi] <= cfg_wdata;
      end
    end

    for (gi = 0; gi < NUM_STE; gi++) begin : g_pred
      always_ff @(posedge clk) begin
        if (reset)
          pred_mem[gi] <= '0;
        else if (cfg_ok && cfg_sel == CFG_SEL_PRED && int'(cfg_addr) == gi)
          pred_mem[gi] <= cfg_wdata;
      end
      assign pred_flat[gi*NUM_STE +: NUM_STE] = pred_mem[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sod_reg      <= '0;
      allin_reg    <= '0;
      rep_mask_reg <= '0;
    end else if (cfg_ok) begin
      if (cfg_sel == CFG_SEL_SOD)    sod_reg      <= cfg_wdata;
      if (cfg_sel == CFG_SEL_ALLIN)  allin_reg    <= cfg_wdata;
      if (cfg_sel == CFG_SEL_REPORT) rep_mask_reg <= cfg_wdata;
    end
  end

  // Stream-control FSM
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    sym_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    first      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_FIRST;
      end
      ST_FIRST: begin
        sym_ready = 1'b1;
        first     = 1'b1;
        if (sym_valid) state_next = sym_last ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        sym_ready = 1'b1;
        if (sym_valid && sym_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept       = sym_valid & sym_ready;
  assign stream_begin = (state_reg == ST_IDLE) & start;
  assign class_row    = class_mem[sym_data];

  ltl_ste_vec #(
    .NUM_STE (NUM_STE)
  ) u_ste_vec (
    .active      (active_reg),
    .class_row   (class_row),
    .pred        (pred_flat),
    .sod         (sod_reg),
    .allin       (allin_reg),
    .first       (first),
    .next_active (next_active)
  );

  assign next_report = next_active & rep_mask_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg       <= '0;
      report_reg       <= '0;
      report_valid_reg <= 1'b0;
      report_any_reg   <= 1'b0;
    end else begin
      report_valid_reg <= accept;
      if (stream_begin) begin
        active_reg     <= '0;
        report_any_reg <= 1'b0;
      end else if (accept) begin
        active_reg <= next_active;
        report_reg <= next_report;
        if (|next_report) report_any_reg <= 1'b1;
      end
    end
  end

  assign report       = report_reg;
  assign report_valid = report_valid_reg;
  assign report_any   = report_any_reg;
  assign cfg_err      = cfg_err_reg;

`ifdef LTL_PROG_AUTOMATON_REPORT_CNT_EN
  // Counts cycles presenting a non-zero report; sticks at all-ones.
  logic [CNT_W-1:0] report_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || stream_begin)
      report_cnt_reg <= '0;
    else if (report_valid_reg && (|report_reg) && !(&report_cnt_reg))
      report_cnt_reg <= report_cnt_reg + 1'b1;
  end

  assign report_cnt = report_cnt_reg;
`endif

endmodule
